mutation_sampler: RTL and testbench
===================================

MUTATION_SAMPLER -- requirements
Module: mutation_sampler

Interface
REQ-001 Parameter: PROB_W, default 16, width of uniform sample and thresholds; legal range 1..16.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rand_val  input  33  free-running pseudo-random word from the upstream 33-bit LFSR; may change every cycle.
REQ-005 in_valid  input  1  parent-state request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_state  input  2  parent nucleotide (0=A,1=C,2=G,3=T).
REQ-008 tbl_wr_en  input  1  threshold-table write strobe.
REQ-009 tbl_addr  input  4  {row[1:0], col[1:0]}; row = parent state, col = threshold index 0..2; col 3 ignored.
REQ-010 tbl_wr_data  input  PROB_W  cumulative threshold value.
REQ-011 out_valid  output  1  sampled child state valid.
REQ-012 out_ready  input  1  downstream accepts child state.
REQ-013 out_state  output  2  sampled child nucleotide.
REQ-014 out_mutated  output  1  out_state differs from parent.
REQ-015 mut_cnt  output  16  count of delivered mutated samples.

Function
REQ-016 Table: 4 rows x 3 registers C[r][0..2], PROB_W bits each.
REQ-017 Write: tbl_wr_en=1 with col<3 -> C[row][col] updated at edge; col=3 -> no effect; writes accepted in any FSM state.
REQ-018 Uniform sample u = rand_val[PROB_W-1:0] XOR rand_val[32:33-PROB_W], width PROB_W.
REQ-019 Selection, row p = latched parent: child = 0 if u<C[p][0]; else 1 if u<C[p][1]; else 2 if u<C[p][2]; else 3; unsigned compare, first match wins, no monotonicity check.
REQ-020 FSM states IDLE, COMPARE, HOLD; in_ready=1 only in IDLE; out_valid=1 only in HOLD.
REQ-021 IDLE: in_valid=1 -> latch in_state and u (from rand_val of that cycle), go COMPARE; else stay.
REQ-022 COMPARE: evaluate REQ-019 with table contents as registered at start of cycle (same-cycle write not visible); register out_state and out_mutated; go HOLD.
REQ-023 HOLD: out_state/out_mutated stable; out_ready=1 -> go IDLE and, if out_mutated=1, increment mut_cnt; out_ready=0 -> stay.
REQ-024 Latency: request accepted at edge N -> out_valid=1 from cycle after edge N+1; max throughput 1 sample per 3 cycles with out_ready tied high.
REQ-025 mut_cnt saturates at 16'hFFFF; never wraps.
REQ-026 in_valid during COMPARE/HOLD ignored (in_ready=0); request must be held by source.
REQ-027 rand_val changes after request acceptance do not affect that sample.

Reset
REQ-028 reset=1 -> immediately: state IDLE, in_ready=1, out_valid=0, out_state=0, out_mutated=0, mut_cnt=0, all C=0, latched parent and u=0.
REQ-029 Reset mid-COMPARE or mid-HOLD drops the pending sample; no output handshake, no count.
REQ-030 With reset table (all zero) every sample yields child=3.

Verification
REQ-031 Table row 0 = {0x4000,0x8000,0xC000}; in_state=0, rand_val=33'h0_0000_3000 -> u=0x3000, out_state=0, out_mutated=0, out_valid 2 cycles after accept.
REQ-032 Same table; rand_val=33'h0_0000_9000 -> out_state=2, out_mutated=1; out_ready=1 -> mut_cnt 0->1.
REQ-033 rand_val=33'h1_0000_0000 (u=0x8000), row 0 as above -> out_state=2 (0x8000 not <0x8000); XOR path check rand_val=33'h0_0002_0000 -> u=0x0001 -> out_state=0.
REQ-034 Hold out_ready=0 for 5 cycles in HOLD, toggle rand_val and in_valid -> out_state unchanged, in_ready=0, mut_cnt unchanged; release -> single count.
REQ-035 Assert reset during HOLD -> out_valid=0, mut_cnt=0, all table entries 0; next request with any rand_val -> out_state=3.
REQ-036 Preload mut_cnt to 0xFFFF via 65535 mutated samples (or force) then one more mutated handshake -> mut_cnt stays 0xFFFF.

Source files
------------

// File: rtl/mutation_sampler.sv
// Samples a child nucleotide from a parent state using a programmable cumulative
// threshold table and a uniform sample derived from an upstream LFSR word.
module mutation_sampler #(
    parameter int PROB_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [32:0]       rand_val,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_state,
    input  logic              tbl_wr_en,
    input  logic [3:0]        tbl_addr,
    input  logic [PROB_W-1:0] tbl_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_state,
    output logic              out_mutated,
    output logic [15:0]       mut_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [1:0]        state;
    logic [PROB_W-1:0] thr [4][3];
    logic [1:0]        parent_q;
    logic [PROB_W-1:0] u_q;
    logic [PROB_W-1:0] u_now;
    logic [1:0]        child;
    logic              unused_rand;

    // Fold both ends of the LFSR word together so every sample mixes high and low bits.
    assign u_now       = rand_val[PROB_W-1:0] ^ rand_val[32 -: PROB_W];
    assign unused_rand = ^rand_val;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    thr[r][c] <= '0;
                end
            end
        end else if (tbl_wr_en && (tbl_addr[1:0] != 2'd3)) begin
            thr[tbl_addr[3:2]][tbl_addr[1:0]] <= tbl_wr_data;
        end
    end

    // First threshold the sample falls below wins; thresholds need not be monotonic.
    always_comb begin
        child = 2'd3;
        if (u_q < thr[parent_q][0]) begin
            child = 2'd0;
        end else if (u_q < thr[parent_q][1]) begin
            child = 2'd1;
        end else if (u_q < thr[parent_q][2]) begin
            child = 2'd2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            parent_q    <= 2'd0;
            u_q         <= '0;
            out_state   <= 2'd0;
            out_mutated <= 1'b0;
            mut_cnt     <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        parent_q <= in_state;
                        u_q      <= u_now;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    out_state   <= child;
                    out_mutated <= (child != parent_q);
                    state       <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                        if (out_mutated && (mut_cnt != 16'hFFFF)) begin
                            mut_cnt <= mut_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mutation_sampler.sv
// Self-checking bench for mutation_sampler: directed and randomized requests
// compared against a behavioural model of the threshold selection.
module tb_mutation_sampler;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [32:0]   rand_val;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_state;
    logic          tbl_wr_en;
    logic [3:0]    tbl_addr;
    logic [PW-1:0] tbl_wr_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_state;
    logic          out_mutated;
    logic [15:0]   mut_cnt;

    int tests = 0;
    int fails = 0;
    int ref_tbl [4][3];
    int ref_cnt = 0;

    mutation_sampler #(.PROB_W(PW)) dut (
        .clk(clk), .reset(reset), .rand_val(rand_val),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .tbl_wr_en(tbl_wr_en), .tbl_addr(tbl_addr), .tbl_wr_data(tbl_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_mutated(out_mutated), .mut_cnt(mut_cnt)
    );

    always #5 clk = ~clk;

    function automatic int model_u(input logic [32:0] rv);
        longint v;
        v = longint'(rv);
        return int'(((v % 65536) ^ (v / 131072)) % 65536);
    endfunction

    function automatic int model_child(input int p, input int u);
        for (int c = 0; c < 3; c++) begin
            if (u < ref_tbl[p][c]) return c;
        end
        return 3;
    endfunction

    function automatic logic [32:0] rand33();
        return {1'($urandom_range(0, 1)), 32'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [32:0] observed, input logic [32:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic writeTbl(input int row, input int col, input int data);
        tbl_wr_en   = 1'b1;
        tbl_addr    = 4'(row * 4 + col);
        tbl_wr_data = PW'(data);
        tick();
        tbl_wr_en = 1'b0;
        if (col < 3) ref_tbl[row][col] = data;
    endtask

    // One full request/response transaction with optional backpressure and a
    // table write landing in the compare cycle (which must not affect this sample).
    task automatic applyStimulus(input int p, input logic [32:0] rv, input int hold, input bit wr_cmp);
        int exp_child;
        int new_val;
        bit exp_mut;
        checkOutput("in_ready_idle", 33'(in_ready), 33'd1);
        in_valid  = 1'b1;
        in_state  = 2'(p);
        rand_val  = rv;
        exp_child = model_child(p, model_u(rv));
        exp_mut   = (exp_child != p);
        tick();
        in_valid = 1'($urandom_range(0, 1));
        rand_val = rand33();
        new_val  = int'($urandom_range(0, 65535));
        if (wr_cmp) begin
            tbl_wr_en   = 1'b1;
            tbl_addr    = 4'(p * 4);
            tbl_wr_data = PW'(new_val);
        end
        checkOutput("compare_in_ready", 33'(in_ready), 33'd0);
        checkOutput("compare_out_valid", 33'(out_valid), 33'd0);
        tick();
        tbl_wr_en = 1'b0;
        if (wr_cmp) ref_tbl[p][0] = new_val;
        checkOutput("hold_out_valid", 33'(out_valid), 33'd1);
        checkOutput("out_state", 33'(out_state), 33'(exp_child));
        checkOutput("out_mutated", 33'(out_mutated), 33'(exp_mut));
        for (int i = 0; i < hold; i++) begin
            rand_val = rand33();
            in_valid = 1'($urandom_range(0, 1));
            tick();
            checkOutput("stall_out_state", 33'(out_state), 33'(exp_child));
            checkOutput("stall_in_ready", 33'(in_ready), 33'd0);
            checkOutput("stall_mut_cnt", 33'(mut_cnt), 33'(ref_cnt));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (exp_mut && ref_cnt < 65535) ref_cnt++;
        checkOutput("mut_cnt", 33'(mut_cnt), 33'(ref_cnt));
        checkOutput("release_out_valid", 33'(out_valid), 33'd0);
    endtask

    initial begin
        reset = 1'b1; rand_val = '0; in_valid = 0; in_state = 0;
        tbl_wr_en = 0; tbl_addr = 0; tbl_wr_data = 0; out_ready = 0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 3; c++) ref_tbl[r][c] = 0;
        #2;
        checkOutput("rst_in_ready", 33'(in_ready), 33'd1);
        checkOutput("rst_out_valid", 33'(out_valid), 33'd0);
        checkOutput("rst_out_state", 33'(out_state), 33'd0);
        checkOutput("rst_out_mutated", 33'(out_mutated), 33'd0);
        checkOutput("rst_mut_cnt", 33'(mut_cnt), 33'd0);
        tick();
        reset = 1'b0;
        tick();

        // Zeroed table always selects child 3.
        applyStimulus(0, rand33(), 0, 0);
        applyStimulus(3, rand33(), 0, 0);

        writeTbl(0, 0, 'h4000);
        writeTbl(0, 1, 'h8000);
        writeTbl(0, 2, 'hC000);
        writeTbl(0, 3, 'h0001);
        applyStimulus(0, 33'h0_0000_3000, 0, 0);
        applyStimulus(0, 33'h0_0000_9000, 0, 0);
        applyStimulus(0, 33'h1_0000_0000, 0, 0);
        applyStimulus(0, 33'h0_0002_0000, 0, 0);
        applyStimulus(0, 33'h0_0000_9000, 5, 0);

        for (int r = 1; r < 4; r++) for (int c = 0; c < 3; c++) writeTbl(r, c, int'($urandom_range(0, 65535)));
        for (int i = 0; i < 24; i++) begin
            applyStimulus(int'($urandom_range(0, 3)), rand33(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset while holding a result drops it and clears table and count.
        in_valid = 1'b1; in_state = 2'd0; rand_val = rand33();
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("pre_reset_out_valid", 33'(out_valid), 33'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset_out_valid", 33'(out_valid), 33'd0);
        checkOutput("mid_reset_mut_cnt", 33'(mut_cnt), 33'd0);
        checkOutput("mid_reset_in_ready", 33'(in_ready), 33'd1);
        for (int r = 0; r < 4; r++) for (int c = 0; c < 3; c++) ref_tbl[r][c] = 0;
        ref_cnt = 0;
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(1, rand33(), 0, 0);
        applyStimulus(2, rand33(), 1, 0);

        // Saturation: preload the counter just below the ceiling.
        force dut.mut_cnt = 16'hFFFE;
        #1;
        release dut.mut_cnt;
        ref_cnt = 65534;
        applyStimulus(0, rand33(), 0, 0);
        applyStimulus(1, rand33(), 0, 0);
        applyStimulus(2, rand33(), 0, 0);
        checkOutput("saturated", 33'(mut_cnt), 33'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
